// File: rtl/mat_mult_stream.sv
// mat_mult_stream: streams in two N x N matrices, streams out their product row-major.
module mat_mult_stream #(
    parameter int elementsNum = 4,
    parameter int dataWidth   = 4,
    parameter int isSigned    = 0,
    localparam int W = 2*dataWidth + $clog2(elementsNum) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [W-1:0]         out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 last
);
    localparam int CW = $clog2(elementsNum);
    localparam int LW = $clog2(2*elementsNum*elementsNum);
    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [CW-1:0] NMAX = CW'(elementsNum - 1);
    localparam logic [LW-1:0] LMAX = LW'(2*elementsNum*elementsNum - 1);
    logic [1:0]           state;
    logic [LW-1:0]        cnt, a_idx, b_idx;
    logic [CW-1:0]        i, j, k;
    logic [W-1:0]         acc, acc_nxt, ea, eb;
    logic [dataWidth-1:0] mem [2*elementsNum*elementsNum];
    logic [dataWidth-1:0] a_el, b_el;
    // A occupies the first N*N entries, B the rest, both row-major
    always_comb begin
        a_idx = LW'(i) * LW'(elementsNum) + LW'(k);
        b_idx = LW'(elementsNum*elementsNum) + LW'(k) * LW'(elementsNum) + LW'(j);
        a_el = mem[a_idx];
        b_el = mem[b_idx];
        ea = {{(W-dataWidth){a_el[dataWidth-1] & (isSigned != 0)}}, a_el};
        eb = {{(W-dataWidth){b_el[dataWidth-1] & (isSigned != 0)}}, b_el};
        acc_nxt = acc + ea * eb;
    end
    assign ready_in  = rst && state == LOAD;
    assign valid_out = state == SEND;
    assign last      = state == SEND && i == NMAX && j == NMAX;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            out   <= '0;
        end else begin
            case (state)
                LOAD: if (valid_in) begin
                    mem[cnt] <= in;
                    cnt      <= cnt == LMAX ? '0 : cnt + 1'b1;
                    if (cnt == LMAX) begin
                        state <= MAC;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k == NMAX ? '0 : k + 1'b1;
                    if (k == NMAX) begin
                        out   <= acc_nxt;
                        state <= SEND;
                    end
                end
                SEND: if (ready_out) begin
                    acc   <= '0;
                    k     <= '0;
                    j     <= j == NMAX ? '0 : j + 1'b1;
                    i     <= j == NMAX ? i + 1'b1 : i;
                    state <= last ? LOAD : MAC;
                    if (last) begin
                        cnt <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_mult_stream.sv
// tb_mat_mult_stream: directed checks of a 2x2 product on unsigned and signed instances.
module tb_mat_mult_stream;
    localparam int N = 2;
    localparam int D = 4;
    localparam int W = 2*D + $clog2(N) + 1;
    logic clk = 0, rst = 0, valid_in = 0, ready_out = 1;
    logic [D-1:0] in_d = '0;
    logic ready_in, valid_out, last, ready_in_s, valid_out_s, last_s;
    logic [W-1:0] out, out_s;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    mat_mult_stream #(.elementsNum(N), .dataWidth(D), .isSigned(0)) dut_u (
        .clk(clk), .rst(rst), .in(in_d), .valid_in(valid_in), .ready_in(ready_in),
        .out(out), .valid_out(valid_out), .ready_out(ready_out), .last(last));
    mat_mult_stream #(.elementsNum(N), .dataWidth(D), .isSigned(1)) dut_s (
        .clk(clk), .rst(rst), .in(in_d), .valid_in(valid_in), .ready_in(ready_in_s),
        .out(out_s), .valid_out(valid_out_s), .ready_out(ready_out), .last(last_s));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // m holds A then B, first element in the top nibble; gaps randomises valid_in
    task automatic load(input logic [31:0] m, input bit gaps);
        int e = 0;
        int guard = 0;
        bit acc;
        while (e < 8 && guard < 200) begin
            valid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_d = m[(7-e)*4 +: 4];
            acc = valid_in && ready_in;
            tick;
            if (acc) e++;
            guard++;
        end
        valid_in = gaps;
        in_d = 4'hF;
        vectors++;
        if (e != 8) begin errors++; $display("FAIL load_timeout accepted=%0d required=8", e); end
        vectors++;
        if (valid_out !== 1'b0 || ready_in !== 1'b0)
            begin errors++; $display("FAIL post_load valid_out=%b ready_in=%b required 0 0", valid_out, ready_in); end
        tick;
        vectors++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL latency_early valid_out=%b required 0", valid_out); end
        tick;
        vectors++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL latency valid_out=%b required 1", valid_out); end
    endtask

    task automatic collect(input logic [39:0] ex, input bit sgn, input bit stall);
        logic [W-1:0] o, e;
        logic l;
        for (int r = 0; r < 4; r++) begin
            int n = 0;
            while (valid_out !== 1'b1 && n < 20) begin tick; n++; end
            vectors++;
            if (valid_out !== 1'b1 || (r > 0 && n != N))
                begin errors++; $display("FAIL result_timing r=%0d edges=%0d required=%0d", r, n, N); end
            e = ex[(3-r)*10 +: 10];
            o = sgn ? out_s : out;
            l = sgn ? last_s : last;
            vectors++;
            if (o !== e || l !== (r == 3))
                begin errors++; $display("FAIL result r=%0d out=%h last=%b required %h %b", r, o, l, e, r == 3); end
            vectors++;
            if (ready_in !== 1'b0) begin errors++; $display("FAIL send_ready_in r=%0d got=%b required 0", r, ready_in); end
            if (stall && r == 0) begin
                ready_out = 0;
                repeat (3) begin
                    tick;
                    o = sgn ? out_s : out;
                    vectors++;
                    if (valid_out !== 1'b1 || o !== e || ready_in !== 1'b0)
                        begin errors++; $display("FAIL stall valid_out=%b out=%h ready_in=%b required 1 %h 0", valid_out, o, ready_in, e); end
                end
                ready_out = 1;
            end
            tick;
            if (r == 3) valid_in = 0;
            vectors++;
            if (valid_out !== 1'b0 || ready_in !== (r == 3))
                begin errors++; $display("FAIL after_xfer r=%0d valid_out=%b ready_in=%b required 0 %b", r, valid_out, ready_in, r == 3); end
        end
    endtask

    task automatic test_reset;
        rst = 0;
        valid_in = 1;
        tick;
        tick;
        vectors++;
        if (ready_in !== 1'b0 || valid_out !== 1'b0 || last !== 1'b0 || out !== '0)
            begin errors++; $display("FAIL reset ready_in=%b valid_out=%b last=%b out=%h required 0 0 0 0", ready_in, valid_out, last, out); end
        rst = 1;
        valid_in = 0;
        #1;
        vectors++;
        if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_release ready_in=%b required 1", ready_in); end
    endtask

    task automatic test_unsigned;
        load(32'h1234_5678, 0);
        collect({10'd19, 10'd22, 10'd43, 10'd50}, 0, 0);
    endtask

    task automatic test_back_to_back;
        load(32'hFFFF_FFFF, 0);
        collect({4{10'd450}}, 0, 0);
    endtask

    task automatic test_signed;
        load(32'hF23C_5678, 0);
        collect({10'h009, 10'h3EA, 10'h3F3, 10'h032}, 1, 0);
    endtask

    task automatic test_stall;
        load(32'h1234_5678, 0);
        collect({10'd19, 10'd22, 10'd43, 10'd50}, 0, 1);
    endtask

    task automatic test_gaps;
        load(32'h1234_5678, 1);
        collect({10'd19, 10'd22, 10'd43, 10'd50}, 0, 0);
    endtask

    task automatic test_mid_reset;
        valid_in = 1;
        for (int e = 0; e < 5; e++) begin
            in_d = 4'(e + 9);
            tick;
        end
        rst = 0;
        in_d = 4'h7;
        tick;
        vectors++;
        if (ready_in !== 1'b0 || valid_out !== 1'b0)
            begin errors++; $display("FAIL mid_reset_low ready_in=%b valid_out=%b required 0 0", ready_in, valid_out); end
        rst = 1;
        valid_in = 0;
        #1;
        vectors++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0)
            begin errors++; $display("FAIL mid_reset_release ready_in=%b valid_out=%b required 1 0", ready_in, valid_out); end
        load(32'h1234_5678, 0);
        collect({10'd19, 10'd22, 10'd43, 10'd50}, 0, 0);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_back_to_back;
        test_signed;
        test_stall;
        test_gaps;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mat_mult_stream.md
MAT_MULT_STREAM -- requirements
Module: mat_mult_stream

Interface
REQ-001 SHALL have parameter elementsNum, default 4: matrix dimension N (square N x N operands); legal range 2..16.
REQ-002 SHALL have parameter dataWidth, default 4: operand element width D in bits.
REQ-003 SHALL have parameter isSigned, default 0: 0 = unsigned operands, 1 = two's-complement operands and result.
REQ-004 SHALL define W = 2*dataWidth + $clog2(elementsNum) + 1 as the result width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low (rst==0 sampled at rising clk edge resets the block).
REQ-007 in  input  D  operand element stream.
REQ-008 valid_in  input  1  in carries a valid element.
REQ-009 ready_in  output  1  block accepts an element this cycle.
REQ-010 out  output  W  result element C[i][j].
REQ-011 valid_out  output  1  out is valid.
REQ-012 ready_out  input  1  downstream accepts out this cycle.
REQ-013 last  output  1  out is C[N-1][N-1], the final element of the result matrix.

Function
REQ-014 SHALL compute C = A x B, with A and B each received as N*N elements, row-major, A fully before B.
REQ-015 Input transfer SHALL occur on a rising edge where valid_in==1 and ready_in==1; no other edge consumes in.
REQ-016 SHALL implement FSM states LOAD, MAC, SEND.
REQ-017 LOAD: ready_in=1; load counter 0..2*N*N-1 increments per transfer; elements 0..N*N-1 store to A, the rest to B; the transfer of element 2*N*N-1 moves the FSM to MAC with i=j=k=0 and accumulator cleared.
REQ-018 MAC: ready_in=0; each edge adds A[i][k]*B[k][j] to the accumulator and increments k; the edge with k==N-1 moves the FSM to SEND.
REQ-019 Products and accumulation SHALL be W bits: zero-extended when isSigned=0, sign-extended when isSigned=1; no overflow is possible at W.
REQ-020 SEND: valid_out=1, out=accumulated C[i][j], last=1 iff i==N-1 and j==N-1; out and last SHALL remain stable while ready_out==0.
REQ-021 Output transfer (valid_out&&ready_out) SHALL advance j (wrap to 0 and increment i at j==N-1), clear the accumulator and k, and enter MAC; if last==1 it SHALL instead enter LOAD with the load counter at 0.
REQ-022 valid_out SHALL rise exactly N edges after the edge accepting the final B element; each further result SHALL appear N edges after the previous output transfer.
REQ-023 valid_out and last SHALL be 0 in LOAD and MAC; out SHALL hold its last value outside SEND.
REQ-024 ready_in SHALL be 0 whenever rst==0, and outside LOAD.
REQ-025 valid_in asserted outside LOAD SHALL be ignored, with no state change.
REQ-026 A new A/B pair SHALL be accepted immediately after the last output transfer, with no idle cycle required.

Reset
REQ-027 On rst==0 at an edge: state=LOAD, all counters=0, accumulator=0, out=0, valid_out=0, last=0; A/B storage need not be cleared.
REQ-028 Reset SHALL take priority over all transfers at the same edge; a partially loaded or partially sent matrix SHALL be discarded.

Verification
REQ-029 N=2, D=4, isSigned=0, A=[1 2;3 4], B=[5 6;7 8], ready_out=1 -> out sequence 19, 22, 43, 50; last only on 50; first valid_out 2 edges after the final B accept.
REQ-030 N=2, D=4, isSigned=1, A=[-1 2;3 -4], B=[5 6;7 -8] -> out 9, -22, -13, 50 as 10-bit two's complement (0x009, 0x3EA, 0x3F3, 0x032).
REQ-031 N=2, D=4 unsigned, all elements 15 -> every out = 450; no wrap.
REQ-032 Same stimulus as REQ-029 with ready_out held 0 for 3 cycles during the first SEND -> out=19, valid_out=1 stable all 3 cycles, no ready_in, sequence otherwise unchanged.
REQ-033 valid_in toggled randomly with gaps during LOAD, and valid_in=1 held during MAC/SEND -> identical results to REQ-029; no extra elements consumed.
REQ-034 rst=0 for one edge after 5 elements loaded -> ready_in=1 and valid_out=0 on the next cycle; a fresh REQ-029 load then yields 19, 22, 43, 50.
